sign_scheduler: RTL

Upstream feeder for the bit-replacement stage. Reads signature bytes from the signature FIFO, serializes them MSB-first into the one-bit sign FIFO, and writes a matching control word per bit into the count FIFO: a 7-bit bit-gap from an LFSR-jittered schedule, plus sign and extend flags. After the payload is exhausted it writes pass-through filler words so the replacement stage keeps draining video.

---
 rtl/sign_scheduler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sign_scheduler.sv
// Serializes signature bytes MSB-first into the sign FIFO and pairs each bit with a
// jittered bit-gap control word; emits pass-through filler words once the payload is done.
module sign_scheduler #(
    parameter logic [15:0] LFSR_DEFAULT = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        frame_start,
    input  logic [6:0]  cfg_base,
    input  logic [6:0]  cfg_jmask,
    input  logic [15:0] cfg_seed,
    input  logic [7:0]  cfg_len,
    input  logic [7:0]  sig_in,
    input  logic        sig_empty,
    output logic        sig_rd,
    output logic [8:0]  cnt_data,
    output logic        cnt_wr,
    input  logic        cnt_afull,
    output logic        sign_data,
    output logic        sign_wr,
    input  logic        sign_afull,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] POLY_MASK = 16'hB400;
    localparam logic [6:0]  GAP_MAX   = 7'd127;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_FILL
    } state_t;

    state_t      state_q,     state_d;
    logic [6:0]  base_q,      base_d;
    logic [6:0]  jmask_q,     jmask_d;
    logic [7:0]  len_q,       len_d;
    logic [15:0] lfsr_q,      lfsr_d;
    logic [7:0]  byte_cnt_q,  byte_cnt_d;
    logic [7:0]  shift_q,     shift_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic [8:0]  cnt_data_q,  cnt_data_d;
    logic        cnt_wr_q,    cnt_wr_d;
    logic        sign_data_q, sign_data_d;
    logic        sign_wr_q,   sign_wr_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;

    logic        wr_en;
    logic [15:0] lfsr_adv;
    logic [7:0]  jitter_sum;
    logic [6:0]  gap;
    logic        last_bit;
    logic [7:0]  byte_next;

    assign wr_en     = clk_en & ~cnt_afull & ~sign_afull;
    assign lfsr_adv  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? POLY_MASK : '0);
    assign last_bit  = (bit_idx_q == 3'd0);
    assign byte_next = byte_cnt_q + 8'd1;

    // Gap is saturated into 1..127 so the replacement stage never sees a zero gap.
    always_comb begin
        jitter_sum = {1'b0, base_q} + {1'b0, lfsr_q[6:0] & jmask_q};
        if (jitter_sum > 8'd127) begin
            gap = GAP_MAX;
        end else if (jitter_sum == 8'd0) begin
            gap = 7'd1;
        end else begin
            gap = jitter_sum[6:0];
        end
    end

    assign sig_rd = (state_q == S_FETCH) & clk_en & ~sig_empty;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        jmask_d     = jmask_q;
        len_d       = len_q;
        lfsr_d      = lfsr_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        cnt_data_d  = cnt_data_q;
        sign_data_d = sign_data_q;
        busy_d      = busy_q;
        cnt_wr_d    = 1'b0;
        sign_wr_d   = 1'b0;
        done_d      = 1'b0;

        if (clk_en) begin
            // frame_start wins over any write decided in the same cycle.
            if (frame_start) begin
                base_d     = cfg_base;
                jmask_d    = cfg_jmask;
                len_d      = cfg_len;
                lfsr_d     = (cfg_seed == 16'd0) ? LFSR_DEFAULT : cfg_seed;
                byte_cnt_d = '0;
                busy_d     = 1'b1;
                state_d    = (cfg_len != 8'd0) ? S_FETCH : S_FILL;
            end else begin
                case (state_q)
                    S_IDLE: begin
                    end
                    S_FETCH: begin
                        if (!sig_empty) begin
                            state_d = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        shift_d   = sig_in;
                        bit_idx_d = 3'd7;
                        state_d   = S_EMIT;
                    end
                    S_EMIT: begin
                        if (wr_en) begin
                            cnt_wr_d    = 1'b1;
                            sign_wr_d   = 1'b1;
                            cnt_data_d  = {last_bit, 1'b1, gap};
                            sign_data_d = shift_q[7];
                            shift_d     = {shift_q[6:0], 1'b0};
                            bit_idx_d   = bit_idx_q - 3'd1;
                            lfsr_d      = lfsr_adv;
                            if (last_bit) begin
                                byte_cnt_d = byte_next;
                                if (byte_next != len_q) begin
                                    state_d = S_FETCH;
                                end else begin
                                    done_d  = 1'b1;
                                    busy_d  = 1'b0;
                                    state_d = S_FILL;
                                end
                            end
                        end
                    end
                    S_FILL: begin
                        // Also covers the zero-length frame, where busy lasts one cycle.
                        busy_d = 1'b0;
                        if (wr_en) begin
                            cnt_wr_d   = 1'b1;
                            cnt_data_d = {1'b0, 1'b0, GAP_MAX};
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            jmask_q     <= '0;
            len_q       <= '0;
            lfsr_q      <= LFSR_DEFAULT;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            cnt_data_q  <= '0;
            cnt_wr_q    <= 1'b0;
            sign_data_q <= 1'b0;
            sign_wr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            jmask_q     <= jmask_d;
            len_q       <= len_d;
            lfsr_q      <= lfsr_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            cnt_data_q  <= cnt_data_d;
            cnt_wr_q    <= cnt_wr_d;
            sign_data_q <= sign_data_d;
            sign_wr_q   <= sign_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cnt_data  = cnt_data_q;
    assign cnt_wr    = cnt_wr_q;
    assign sign_data = sign_data_q;
    assign sign_wr   = sign_wr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
